core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory between NUM_CORES cores.
- Registers one winning request per cycle onto the memory port, returns a one-cycle grant (acceptance) pulse to the winner, and routes read data back to the issuing core after a fixed memory latency.
- Sits beside Task_Scheduler, between the core array and the shared data memory.

Parameters:
- NUM_CORES, 4, number of requesting cores (>=2).
- ADDR_W, 8, memory address width.
- DATA_W, 8, memory data width.
- MEM_LAT, 2, cycles from accepted read (mem_en & mem_ready) to mem_rdata valid (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req  in  NUM_CORES  per-core request, held until gnt.
- req_we  in  NUM_CORES  per-core write enable (1 = write, 0 = read).
- req_addr  in  NUM_CORES*ADDR_W  flat; core i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_CORES*DATA_W  flat; core i at [i*DATA_W +: DATA_W].
- gnt  out  NUM_CORES  one-hot pulse: core's transaction accepted by memory this cycle.
- rd_valid  out  NUM_CORES  one-hot pulse: rd_data belongs to core i.
- rd_data  out  DATA_W  read return data (= mem_rdata).
- mem_en  out  1  memory transaction valid (registered).
- mem_we  out  1  registered write enable.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ready  in  1  memory accepts the transaction when mem_en & mem_ready.
- mem_rdata  in  DATA_W  read data, valid MEM_LAT cycles after a read is accepted.

Behaviour:
- Reset (reset==0 at posedge):
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - owner=0, rr_ptr=0, tag pipeline cleared.
  - Consequently gnt=0 and rd_valid=0.
  - An in-flight read is dropped: no rd_valid after reset.
- State:
  - Slot register: mem_en/mem_we/mem_addr/mem_wdata/owner (one-hot).
  - rr_ptr: index of highest-priority core.
  - Tag shift register: MEM_LAT stages x NUM_CORES.
- accept = mem_en & mem_ready. gnt = accept ? owner : 0 (combinational from registers).
- slot_free = ~mem_en | accept.
- Eligibility: eligible = req & ~(accept ? owner : 0). A core is never re-granted on the cycle its gnt is high, even if req is still asserted.
- Arbitration, when slot_free and eligible != 0:
  - Winner w is the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo NUM_CORES.
  - Next cycle: mem_en=1, fields loaded from core w, owner=1<<w, rr_ptr=(w+1) mod NUM_CORES.
- slot_free and eligible == 0: mem_en<=0. rr_ptr and other fields hold.
- Stall: mem_en & ~mem_ready holds all slot fields unchanged. No arbitration and no rr_ptr change.
- Latency: request seen at posedge N with slot free -> mem_en at N+1 -> gnt in the first cycle with mem_ready=1. Minimum 1 cycle from req to gnt. Back-to-back accepts possible every cycle.
- Read return:
  - Tag stage 0 loads (accept & ~mem_we) ? owner : 0 every cycle; the pipeline shifts every cycle regardless of stall.
  - rd_valid = stage MEM_LAT-1; rd_data = mem_rdata.
- Writes produce no rd_valid.
- Requester rule: change req/fields only after gnt. A core dropping req before gnt is legal; the already-registered slot still issues.
- Outstanding reads from different cores return in acceptance order, one per cycle max.

Optional Feature:
- Macro ARB_LOCK_EN adds input lock[NUM_CORES].
- With the macro:
  - If the accepted transaction's core has lock=1, the arbiter enters LOCKED and the eligible set becomes only that core until it is accepted with lock=0. This gives atomic read-modify-write sequences.
  - rr_ptr is frozen while LOCKED and updates on the unlocking grant.
  - Reset clears LOCKED.
- Without the macro: no lock port, pure round-robin.

Test Plan:
- Reset: hold reset=0 with req=4'b1111 -> mem_en=0, gnt=0, rd_valid=0. On the first cycle after release, core 0 is loaded; gnt=4'b0001 the next cycle (mem_ready=1).
- Fairness: req=4'b1111 held (re-asserted after each gnt), mem_ready=1 -> gnt sequence 0001,0010,0100,1000,0001, one per cycle.
- Stall: core 2 write addr 8'h10 data 8'hA5, mem_ready=0 for 3 cycles -> mem_en/addr/wdata stable, gnt=0. On mem_ready=1: gnt=4'b0100 for one cycle, then rr_ptr=3.
- Read tagging, MEM_LAT=2: core 1 reads 8'h20 and core 3 reads 8'h21 on consecutive accepts, memory returns 8'h11 then 8'h33 -> rd_valid=0010 with rd_data=8'h11, next cycle rd_valid=1000 with rd_data=8'h33.
- Double-grant guard: core 0 keeps req=1 for one cycle after gnt with req=4'b0001 only -> exactly one gnt; the second mem_en appears only after req re-rises.
- Reset mid-read: reset=0 one cycle after a read accept -> no rd_valid pulse afterward.
- ARB_LOCK_EN: core 1 locked for 2 transactions while core 2 requests -> gnt 0010,0010 (second with lock=0), then 0100.

Source files
------------

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter sharing one single-port data memory
// between NUM_CORES cores. One winning request is registered per cycle onto
// the memory port, the winner gets a one-cycle gnt pulse when the memory
// accepts it, and read data is steered back to the issuing core MEM_LAT
// cycles after acceptance through a one-hot tag pipeline.
// Optional build macro ARB_LOCK_EN adds a per-core lock input that keeps the
// memory dedicated to one core across a locked read-modify-write sequence.
module core_mem_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8,
   parameter int MEM_LAT   = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_CORES-1:0]          req,
   input  logic [NUM_CORES-1:0]          req_we,
   input  logic [NUM_CORES*ADDR_W-1:0]   req_addr,
   input  logic [NUM_CORES*DATA_W-1:0]   req_wdata,
`ifdef ARB_LOCK_EN
   input  logic [NUM_CORES-1:0]          lock,
`endif
   output logic [NUM_CORES-1:0]          gnt,
   output logic [NUM_CORES-1:0]          rd_valid,
   output logic [DATA_W-1:0]             rd_data,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic                          mem_ready,
   input  logic [DATA_W-1:0]             mem_rdata
);

   localparam int PTR_W = $clog2(NUM_CORES);

   logic [NUM_CORES-1:0] owner;
   logic [PTR_W-1:0]     rr_ptr;
   logic [NUM_CORES-1:0] tag_pipe [MEM_LAT];

   logic                 accept;
   logic                 slot_free;
   logic [NUM_CORES-1:0] eligible;
   logic                 ptr_en;
   logic                 found;
   logic [PTR_W-1:0]     win_idx;
   logic [PTR_W-1:0]     next_ptr;
   int                   scan_idx;

   assign accept    = mem_en & mem_ready;
   assign gnt       = accept ? owner : '0;
   assign slot_free = ~mem_en | accept;
   assign rd_valid  = tag_pipe[MEM_LAT-1];
   assign rd_data   = mem_rdata;

`ifdef ARB_LOCK_EN
   typedef enum logic {ARB_OPEN, ARB_LOCKED} lock_state_t;

   lock_state_t          lock_state;
   logic [NUM_CORES-1:0] lock_core;
   logic                 slot_lock;
   logic                 lock_hold;
   logic [NUM_CORES-1:0] lock_mask;

   // Restrict eligibility to the locked core while a locked sequence is open,
   // including the very cycle the locking transaction is accepted, so no other
   // core can slip into the slot between the halves of an atomic sequence.
   always_comb begin
      lock_hold = 1'b0;
      lock_mask = '1;
      if (accept && slot_lock) begin
         lock_hold = 1'b1;
         lock_mask = owner;
      end else if (lock_state == ARB_LOCKED && !accept) begin
         lock_hold = 1'b1;
         lock_mask = lock_core;
      end
   end

   assign eligible = req & ~gnt & lock_mask;
   assign ptr_en   = ~lock_hold;

   // Track lock state from each accepted transaction's captured lock bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         lock_state <= ARB_OPEN;
         lock_core  <= '0;
         slot_lock  <= 1'b0;
      end else begin
         if (accept) begin
            lock_state <= slot_lock ? ARB_LOCKED : ARB_OPEN;
            lock_core  <= owner;
         end
         if (slot_free) begin
            slot_lock <= found ? lock[win_idx] : 1'b0;
         end
      end
   end
`else
   assign eligible = req & ~gnt;
   assign ptr_en   = 1'b1;
`endif

   // Pick the first eligible core scanning upward from rr_ptr with wraparound.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      scan_idx = 0;
      for (int k = 0; k < NUM_CORES; k++) begin
         scan_idx = (int'(rr_ptr) + k) % NUM_CORES;
         if (!found && eligible[scan_idx]) begin
            found   = 1'b1;
            win_idx = PTR_W'(scan_idx);
         end
      end
      next_ptr = (win_idx == PTR_W'(NUM_CORES-1)) ? '0 : win_idx + PTR_W'(1);
   end

   // Slot register: load the winner whenever the slot is free, hold on stall.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         owner     <= '0;
         rr_ptr    <= '0;
      end else if (slot_free) begin
         if (found) begin
            mem_en    <= 1'b1;
            mem_we    <= req_we[win_idx];
            mem_addr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            owner     <= {{(NUM_CORES-1){1'b0}}, 1'b1} << win_idx;
            if (ptr_en) begin
               rr_ptr <= next_ptr;
            end
         end else begin
            mem_en <= 1'b0;
         end
      end
   end

   // Tag pipeline: carries the owner of each accepted read to its data return.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= (accept && !mem_we) ? owner : '0;
         for (int i = 1; i < MEM_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: randomized scoreboard bench for core_mem_arbiter.
// A transaction-level reference model predicts every grant and read return;
// a negedge monitor pops those predictions when the DUT shows gnt/rd_valid.
module tb_core_mem_arbiter;

   localparam int N  = 4;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int ML = 2;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req;
   logic [N-1:0]    req_we;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rd_valid;
   logic [DW-1:0]   rd_data;
   logic            mem_en;
   logic            mem_we;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic            mem_ready;
   logic [DW-1:0]   mem_rdata;

   core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML)) dut (
      .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   typedef struct {
      int         cyc;
      int         core;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
   } gnt_t;

   typedef struct {
      int         cyc;
      int         core;
      logic [7:0] data;
   } rd_t;

   gnt_t exp_gnt_q[$];
   rd_t  exp_rd_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit mon_on = 0;

   // Requester-side state of each core's pending transaction.
   bit         p_req   [N];
   bit         p_we    [N];
   logic [7:0] p_addr  [N];
   logic [7:0] p_wdata [N];

   // Reference model: which core's transaction occupies the memory slot.
   int         m_slot;
   bit         m_we;
   logic [7:0] m_addr;
   logic [7:0] m_wdata;
   int         m_rr;
   bit         m_read_acc;
   logic [7:0] ref_mem [256];
   bit         ref_wr  [256];

   // Behavioural memory attached to the DUT port.
   logic [7:0] phys_mem [256];
   bit         phys_wr  [256];
   logic [7:0] rd_pipe  [ML];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] initVal(input logic [7:0] a);
      return a * 8'd7 + 8'd3;
   endfunction

   assign mem_rdata = rd_pipe[ML-1];

   // Memory: accept on mem_en & mem_ready, return read data ML cycles later.
   always @(posedge clk) begin
      if (mem_en && mem_ready) begin
         if (mem_we) begin
            phys_mem[mem_addr] <= mem_wdata;
            phys_wr[mem_addr]  <= 1'b1;
         end
         rd_pipe[0] <= mem_we ? 8'h00 : (phys_wr[mem_addr] ? phys_mem[mem_addr] : initVal(mem_addr));
      end else begin
         rd_pipe[0] <= 8'h00;
      end
      for (int i = 1; i < ML; i++) begin
         rd_pipe[i] <= rd_pipe[i-1];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // One clock of stimulus: refresh requesters, drive pins, advance the model.
   task automatic applyStimulus(input bit rst_n, input int ready_pct, input int req_pct, input int drop_pct);
      int  acc;
      bit  got;
      rd_t keep[$];
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
         if (!p_req[i] && $urandom_range(99) < req_pct) begin
            p_req[i]   = 1'b1;
            p_we[i]    = 1'($urandom_range(1));
            p_addr[i]  = 8'($urandom_range(15));
            p_wdata[i] = 8'($urandom_range(255));
         end else if (p_req[i] && $urandom_range(99) < drop_pct) begin
            p_req[i] = 1'b0;
         end
         req[i]              = p_req[i];
         req_we[i]           = p_we[i];
         req_addr[i*AW +: AW]  = p_addr[i];
         req_wdata[i*DW +: DW] = p_wdata[i];
      end
      reset     = rst_n;
      mem_ready = rst_n && ($urandom_range(99) < ready_pct);
      m_read_acc = 1'b0;
      if (!rst_n) begin
         m_slot = -1;
         m_rr   = 0;
         foreach (exp_rd_q[j]) if (exp_rd_q[j].cyc <= cyc) keep.push_back(exp_rd_q[j]);
         exp_rd_q = keep;
      end else begin
         acc = -1;
         if (m_slot >= 0 && mem_ready) begin
            acc = m_slot;
            exp_gnt_q.push_back('{cyc, m_slot, m_we, m_addr, m_wdata});
            if (m_we) begin
               ref_mem[m_addr] = m_wdata;
               ref_wr[m_addr]  = 1'b1;
            end else begin
               exp_rd_q.push_back('{cyc + ML, m_slot, ref_wr[m_addr] ? ref_mem[m_addr] : initVal(m_addr)});
               m_read_acc = 1'b1;
            end
            p_req[acc] = 1'b0;
         end
         if (m_slot < 0 || acc >= 0) begin
            m_slot = -1;
            got    = 1'b0;
            for (int k = 0; k < N; k++) begin
               int c;
               c = (m_rr + k) % N;
               if (!got && req[c] && c != acc) begin
                  got     = 1'b1;
                  m_slot  = c;
                  m_we    = req_we[c];
                  m_addr  = req_addr[c*AW +: AW];
                  m_wdata = req_wdata[c*DW +: DW];
                  m_rr    = (c + 1) % N;
               end
            end
         end
      end
   endtask

   // Monitor: pop a prediction whenever the DUT presents gnt or rd_valid.
   always @(negedge clk) begin
      gnt_t g;
      rd_t  r;
      if (mon_on) begin
         if (gnt !== '0) begin
            if (exp_gnt_q.size() == 0) begin
               checkOutput("gnt_unexpected", 32'(gnt), 32'd0);
            end else begin
               g = exp_gnt_q.pop_front();
               checkOutput("gnt_core", 32'(gnt), 32'd1 << g.core);
               checkOutput("gnt_cycle", 32'(cyc), 32'(g.cyc));
               checkOutput("mem_we", 32'(mem_we), 32'(g.we));
               checkOutput("mem_addr", 32'(mem_addr), 32'(g.addr));
               if (g.we) checkOutput("mem_wdata", 32'(mem_wdata), 32'(g.wdata));
            end
         end else if (exp_gnt_q.size() > 0 && exp_gnt_q[0].cyc <= cyc) begin
            g = exp_gnt_q.pop_front();
            checkOutput("gnt_missing", 32'(gnt), 32'd1 << g.core);
         end
         if (rd_valid !== '0) begin
            if (exp_rd_q.size() == 0) begin
               checkOutput("rd_unexpected", 32'(rd_valid), 32'd0);
            end else begin
               r = exp_rd_q.pop_front();
               checkOutput("rd_core", 32'(rd_valid), 32'd1 << r.core);
               checkOutput("rd_cycle", 32'(cyc), 32'(r.cyc));
               checkOutput("rd_data", 32'(rd_data), 32'(r.data));
            end
         end else if (exp_rd_q.size() > 0 && exp_rd_q[0].cyc <= cyc) begin
            r = exp_rd_q.pop_front();
            checkOutput("rd_missing", 32'(rd_valid), 32'd1 << r.core);
         end
      end
   end

   initial begin
      int waited;
      reset = 1'b0; mem_ready = 1'b0;
      req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
      for (int i = 0; i < N; i++) begin
         p_req[i] = 1'b0; p_we[i] = 1'b0; p_addr[i] = 8'h00; p_wdata[i] = 8'h00;
      end
      m_slot = -1; m_rr = 0; m_we = 1'b0; m_addr = 8'h00; m_wdata = 8'h00;

      // Reset held with every core requesting.
      applyStimulus(0, 0, 100, 0);
      applyStimulus(0, 0, 100, 0);
      mon_on = 1'b1;
      repeat (2) begin
         applyStimulus(0, 0, 100, 0);
         #1;
         checkOutput("reset_mem_en", 32'(mem_en), 32'd0);
         checkOutput("reset_gnt", 32'(gnt), 32'd0);
         checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
      end

      // Fairness: all cores requesting continuously, memory always ready.
      repeat (16) applyStimulus(1, 100, 100, 0);

      // Random traffic with stalls and occasional request withdrawal.
      repeat (300) applyStimulus(1, 60, 50, 3);

      // Reset one cycle after a read is accepted: that read never returns.
      waited = 0;
      while (!m_read_acc && waited < 200) begin
         applyStimulus(1, 70, 60, 0);
         waited++;
      end
      if (!m_read_acc) checkOutput("mid_read_wait", 32'd0, 32'd1);
      applyStimulus(0, 0, 60, 0);
      repeat (3) begin
         applyStimulus(1, 100, 60, 0);
         #1;
         checkOutput("post_reset_rd_valid", 32'(rd_valid), 32'd0);
      end

      repeat (300) applyStimulus(1, 80, 40, 2);

      // Drain outstanding work and confirm every prediction was consumed.
      repeat (20) applyStimulus(1, 100, 0, 0);
      #1;
      checkOutput("gnt_queue_empty", 32'(exp_gnt_q.size()), 32'd0);
      checkOutput("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
